// File: rtl/reset_sequencer.sv
// reset_sequencer: brings up an MMCM and releases the SoC reset once the
// MMCM reports lock. A lock attempt that times out is retried a bounded
// number of times before the sequencer parks in FAULT. A debounced button
// press restarts the whole sequence from any state.
//
// Ports
//   clk          board oscillator clock, the only clock domain
//   rst_n        asynchronous active-low reset
//   btn          raw reset-request button (async, active-high)
//   mmcm_locked  MMCM LOCKED (async to clk)
//   mmcm_rst     active-high MMCM reset (registered)
//   core_rst_n   active-low SoC reset (async assert, sync release)
//   state        current FSM state
//   retry_cnt    failed lock attempts since last RUN entry or press
//   fault        high while in FAULT
//   lock_lost    sticky: lock dropped while in RUN
//
// state       | meaning
// RESET_MMCM  | hold MMCM in reset for MMCM_RST_CYCLES
// WAIT_LOCK   | wait up to LOCK_TIMEOUT cycles for lock
// HOLD        | lock seen, keep core in reset for HOLD_CYCLES
// RUN         | core released, watching for lock loss
// FAULT       | retries exhausted, wait for a button press
module reset_sequencer #(
  parameter int MMCM_RST_CYCLES = 8,
  parameter int LOCK_TIMEOUT    = 1000,
  parameter int HOLD_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_RETRIES     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       mmcm_locked,
  output logic       mmcm_rst,
  output logic       core_rst_n,
  output logic [2:0] state,
  output logic [3:0] retry_cnt,
  output logic       fault,
  output logic       lock_lost
);

  localparam int MAX_AB = (MMCM_RST_CYCLES > LOCK_TIMEOUT) ? MMCM_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD = (HOLD_CYCLES > DEBOUNCE_CYCLES) ? HOLD_CYCLES : DEBOUNCE_CYCLES;
  localparam int MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W  = $clog2(MAX_T) + 1;

  localparam logic [CNT_W-1:0] MMCM_LAST = CNT_W'(MMCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_MAX    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_MMCM = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_HOLD       = 3'd2,
    S_RUN        = 3'd3,
    S_FAULT      = 3'd4
  } state_t;

  logic             r_btn_meta, r_btn_s;
  logic             r_lock_meta, r_lock_s;
  logic [CNT_W-1:0] r_db_cnt;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;
  logic [3:0]       r_retry;
  logic             r_mmcm_rst, r_core_rst_n, r_fault, r_lock_lost;

  state_t           w_state_nxt;
  logic [3:0]       w_retry_nxt;
  logic             w_set_lost;
  logic             w_restart;
  logic             w_cnt_clr;
  logic             w_timed;
  logic             w_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_meta  <= 1'b0;
      r_btn_s     <= 1'b0;
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_btn_meta  <= btn;
      r_btn_s     <= r_btn_meta;
      r_lock_meta <= mmcm_locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  // Count saturates one past the fire point so a held button fires once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt <= '0;
    end else if (!r_btn_s) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt != DB_MAX) begin
      r_db_cnt <= r_db_cnt + CNT_W'(1);
    end
  end

  assign w_press = r_btn_s && (r_db_cnt == DB_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    w_set_lost  = 1'b0;
    w_restart   = 1'b0;
    if (w_press) begin
      w_state_nxt = S_RESET_MMCM;
      w_retry_nxt = 4'd0;
      w_restart   = 1'b1;
    end else begin
      case (r_state)
        S_RESET_MMCM: begin
          if (r_cnt == MMCM_LAST) w_state_nxt = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (r_lock_s) begin
            w_state_nxt = S_HOLD;
          end else if (r_cnt == TO_LAST) begin
            if (r_retry == RETRY_MAX) begin
              w_state_nxt = S_FAULT;
            end else begin
              w_state_nxt = S_RESET_MMCM;
              if (r_retry != 4'hF) w_retry_nxt = r_retry + 4'd1;
            end
          end
        end
        S_HOLD: begin
          if (!r_lock_s) begin
            w_state_nxt = S_RESET_MMCM;
          end else if (r_cnt == HOLD_LAST) begin
            w_state_nxt = S_RUN;
            w_retry_nxt = 4'd0;
          end
        end
        S_RUN: begin
          if (!r_lock_s) begin
            w_set_lost  = 1'b1;
            w_state_nxt = S_RESET_MMCM;
          end
        end
        S_FAULT: begin
          w_state_nxt = S_FAULT;
        end
        default: begin
          w_state_nxt = S_RESET_MMCM;
        end
      endcase
    end
  end

  // A press while already in RESET_MMCM is a re-entry and restarts the timer.
  assign w_cnt_clr = w_restart || (w_state_nxt != r_state);
  assign w_timed   = (r_state == S_RESET_MMCM) || (r_state == S_WAIT_LOCK) ||
                     (r_state == S_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_RESET_MMCM;
      r_cnt        <= '0;
      r_retry      <= 4'd0;
      r_mmcm_rst   <= 1'b1;
      r_core_rst_n <= 1'b0;
      r_fault      <= 1'b0;
      r_lock_lost  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_timed) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_retry    <= w_retry_nxt;
      r_mmcm_rst <= (w_state_nxt == S_RESET_MMCM) || (w_state_nxt == S_FAULT);
      r_fault    <= (w_state_nxt == S_FAULT);
      // Release one edge after RUN entry (HOLD_CYCLES+1 edges after HOLD
      // entry), but drop on the same edge that leaves RUN.
      r_core_rst_n <= (r_state == S_RUN) && (w_state_nxt == S_RUN);
      r_lock_lost  <= r_lock_lost | w_set_lost;
    end
  end

  assign mmcm_rst   = r_mmcm_rst;
  assign core_rst_n = r_core_rst_n;
  assign state      = r_state;
  assign retry_cnt  = r_retry;
  assign fault      = r_fault;
  assign lock_lost  = r_lock_lost;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn = 1'b0;
  logic       mmcm_locked = 1'b0;
  logic       mmcm_rst;
  logic       core_rst_n;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  logic       fault;
  logic       lock_lost;

  int checks = 0;
  int failures = 0;

  reset_sequencer #(
    .MMCM_RST_CYCLES(4),
    .LOCK_TIMEOUT   (20),
    .HOLD_CYCLES    (8),
    .DEBOUNCE_CYCLES(4),
    .MAX_RETRIES    (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .mmcm_locked(mmcm_locked),
    .mmcm_rst   (mmcm_rst),
    .core_rst_n (core_rst_n),
    .state      (state),
    .retry_cnt  (retry_cnt),
    .fault      (fault),
    .lock_lost  (lock_lost)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full output vector check: state, mmcm_rst, core_rst_n, retry, fault, lock_lost
  task automatic chk_all(input string tag, input logic [2:0] st, input logic mr,
                         input logic cr, input logic [3:0] rc, input logic ft,
                         input logic ll);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".mmcm_rst"}, 32'(mmcm_rst), 32'(mr));
    chk({tag, ".core_rst_n"}, 32'(core_rst_n), 32'(cr));
    chk({tag, ".retry"}, 32'(retry_cnt), 32'(rc));
    chk({tag, ".fault"}, 32'(fault), 32'(ft));
    chk({tag, ".lock_lost"}, 32'(lock_lost), 32'(ll));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk_all("rst_async", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(2);
    chk_all("rst_held", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Power-up: mmcm_rst high 4 cycles, lock 3 cycles after, HOLD, RUN
    tick(3);
    chk_all("pu_mrst_hi", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(1);
    chk_all("pu_wait", 3'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(2);
    mmcm_locked = 1'b1;
    tick(2);
    chk("pu_sync_lat", 32'(state), 32'd1);
    tick(1);
    chk("pu_hold", 32'(state), 32'd2);
    tick(7);
    chk_all("pu_hold_end", 3'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(1);
    chk_all("pu_run_entry", 3'd3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(1);
    chk_all("pu_run", 3'd3, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);

    // Lock drop for one cycle in RUN
    mmcm_locked = 1'b0;
    tick(1);
    mmcm_locked = 1'b1;
    tick(1);
    chk("ll_pre.core", 32'(core_rst_n), 32'd1);
    tick(1);
    chk_all("ll_drop", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    tick(4);
    chk_all("ll_wait", 3'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    tick(1);
    chk("ll_hold", 32'(state), 32'd2);
    tick(8);
    chk("ll_run", 32'(state), 32'd3);
    tick(1);
    chk_all("ll_run_out", 3'd3, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);

    // Button bounce: 3-cycle high pulses must not register
    for (int i = 0; i < 3; i++) begin
      btn = 1'b1;
      tick(3);
      btn = 1'b0;
      tick(3);
    end
    tick(4);
    chk_all("bounce", 3'd3, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);

    // Held press: one event, sequence completes while still held
    btn = 1'b1;
    tick(5);
    chk_all("press_pre", 3'd3, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    tick(1);
    chk_all("press_evt", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    tick(14);
    chk_all("press_held_run", 3'd3, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    btn = 1'b0;
    tick(4);

    // Lock held low: three timeouts, retry 1, 2, then FAULT
    mmcm_locked = 1'b0;
    tick(3);
    chk_all("to_drop", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    tick(4);
    chk("to_wait1", 32'(state), 32'd1);
    tick(19);
    chk_all("to_wait1_end", 3'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    tick(1);
    chk_all("to_retry1", 3'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1);
    tick(4);
    chk("to_wait2", 32'(state), 32'd1);
    tick(20);
    chk_all("to_retry2", 3'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1);
    tick(4);
    chk("to_wait3", 32'(state), 32'd1);
    tick(19);
    chk("to_wait3_end", 32'(state), 32'd1);
    tick(1);
    chk_all("to_fault", 3'd4, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1);

    // FAULT is sticky even with lock back; press recovers
    mmcm_locked = 1'b1;
    tick(10);
    chk_all("fault_stay", 3'd4, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1);
    btn = 1'b1;
    tick(5);
    chk("fp_pre.fault", 32'(fault), 32'd1);
    tick(1);
    chk_all("fp_evt", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    btn = 1'b0;
    tick(4);
    chk("fp_wait", 32'(state), 32'd1);
    tick(1);
    chk("fp_hold", 32'(state), 32'd2);
    tick(9);
    chk_all("fp_run", 3'd3, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);

    // rst_n in RUN: immediate, mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk_all("rr_run", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk("rr_mrst_hi", 32'(mmcm_rst), 32'd1);
    tick(1);
    chk_all("rr_wait", 3'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(1);
    chk("rr_hold", 32'(state), 32'd2);

    // rst_n in HOLD
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    chk_all("rh_hold", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk("rh_mrst_hi", 32'(mmcm_rst), 32'd1);
    tick(1);
    chk_all("rh_wait", 3'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(1);
    chk("rh_hold2", 32'(state), 32'd2);
    tick(9);
    chk_all("rh_run", 3'd3, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
